// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read bus and CPU-controller handshake
// bundled between fetch_sequencer (master) and its neighbours.
interface fetch_sequencer_if;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic        mem_rdy;
  logic [15:0] mem_data;
  logic [15:0] inst;
  logic        run;
  logic        done;
  logic [1:0]  cmp_flag;

  modport master (
    output mem_addr, mem_rd, inst, run,
    input  mem_rdy, mem_data, done, cmp_flag
  );

  modport slave (
    input  mem_addr, mem_rd, inst, run,
    output mem_rdy, mem_data, done, cmp_flag
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/decode/issue sequencer in front of the CPU controller.
// Define FETCH_BRANCH_EN to resolve branches (inst[1:0]==2'b10) locally.
module fetch_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  fetch_sequencer_if.master bus,
  output logic [7:0]  pc,
  output logic        halted,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    WAIT,
    HALT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] inst_q;
  logic [15:0] inst_nxt;
  logic [7:0]  pc_nxt;
  logic [15:0] cnt_nxt;
  logic [7:0]  pc_inc;
  logic [7:0]  br_pc;
  logic        is_halt;
  logic        is_branch;

  assign pc_inc  = pc + 8'd1;
  assign is_halt = (inst_q == 16'hFFFF);

`ifdef FETCH_BRANCH_EN
  logic taken;

  assign is_branch = (inst_q[1:0] == 2'b10);

  always_comb begin
    taken = 1'b0;
    unique case (inst_q[3:2])
      2'b00: taken = (bus.cmp_flag == 2'b00);
      2'b01: taken = (bus.cmp_flag == 2'b01);
      2'b10: taken = (bus.cmp_flag == 2'b10);
      2'b11: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign br_pc = taken ? inst_q[11:4] : pc_inc;
`else
  logic unused_cmp;

  // Branch format goes to the CPU controller like any other word.
  assign is_branch  = 1'b0;
  assign br_pc      = pc_inc;
  assign unused_cmp = ^bus.cmp_flag;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= 8'h00;
      inst_q      <= 16'h0000;
      instr_count <= 16'h0000;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      inst_q      <= inst_nxt;
      instr_count <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    inst_nxt  = inst_q;
    cnt_nxt   = instr_count;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        if (bus.mem_rdy) begin
          inst_nxt  = bus.mem_data;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (is_halt) begin
          state_nxt = HALT;
        end else if (is_branch) begin
          pc_nxt    = br_pc;
          cnt_nxt   = instr_count + 16'd1;
          state_nxt = FETCH;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.done) begin
          pc_nxt    = pc_inc;
          cnt_nxt   = instr_count + 16'd1;
          state_nxt = FETCH;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are forced low while reset is held, whatever the state.
  assign bus.mem_rd   = !reset && (state == FETCH);
  assign bus.run      = !reset && (state == DECODE)
                        && !is_halt && !is_branch;
  assign halted       = !reset && (state == HALT);
  assign bus.mem_addr = pc;
  assign bus.inst     = inst_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: memory and CPU-controller
// models drive the bus, a negedge monitor checks run/halt events.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] instr_count;

  fetch_sequencer_if ifc();

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (ifc.master),
    .pc          (pc),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_halt;
    logic [7:0]  pc;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem [256];
  int          checks = 0;
  int          errors = 0;
  int          rdy_lat = 1;
  bit          done_auto = 1'b1;
  logic        halted_q = 1'b0;

  function automatic void check(string name, logic [31:0] got,
                                logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic void push(bit h, logic [7:0] p, logic [15:0] v);
    exp_t e;
    e.is_halt = h;
    e.pc      = p;
    e.val     = v;
    sb.push_back(e);
  endfunction

  // Memory: mem_rdy rises in the rdy_lat-th cycle of a FETCH.
  initial begin
    int n;
    n = 0;
    ifc.mem_rdy  = 1'b0;
    ifc.mem_data = 16'hDEAD;
    forever begin
      @(posedge clk);
      #1;
      if (ifc.mem_rd) begin
        n++;
        if (n >= rdy_lat) begin
          ifc.mem_rdy  = 1'b1;
          ifc.mem_data = mem[ifc.mem_addr];
        end
      end else begin
        n = 0;
        ifc.mem_rdy  = 1'b0;
        ifc.mem_data = 16'hDEAD;
      end
    end
  end

  // CPU controller: done pulse two cycles after run.
  initial begin
    ifc.done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ifc.run && done_auto) begin
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        ifc.done = 1'b1;
        @(posedge clk);
        #1;
        ifc.done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ifc.run) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL run_unexpected pc %0h inst %0h", pc, ifc.inst);
      end else begin
        e = sb.pop_front();
        check("run_kind", {31'd0, e.is_halt}, 32'd0);
        check("run_pc", {24'd0, pc}, {24'd0, e.pc});
        check("run_inst", {16'd0, ifc.inst}, {16'd0, e.val});
      end
    end
    if (halted && !halted_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL halt_unexpected pc %0h", pc);
      end else begin
        e = sb.pop_front();
        check("halt_kind", {31'd0, e.is_halt}, 32'd1);
        check("halt_pc", {24'd0, pc}, {24'd0, e.pc});
        check("halt_count", {16'd0, instr_count}, {16'd0, e.val});
      end
    end
    halted_q <= halted;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", {24'd0, pc}, 32'd0);
    check("rst_cnt", {16'd0, instr_count}, 32'd0);
    check("rst_inst", {16'd0, ifc.inst}, 32'd0);
    check("rst_strobes", {29'd0, ifc.mem_rd, ifc.run, halted}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(string name, int bound);
    int n;
    n = 0;
    while (!halted && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({name, "_halted"}, {31'd0, halted}, 32'd1);
    @(negedge clk);
    check({name, "_sb_empty"}, sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic branch_case(string name, logic [1:0] cmp,
                             logic [15:0] br, bit exp_taken);
    foreach (mem[i]) mem[i] = 16'hFFFF;
    mem[0]    = 16'h0001;
    mem[1]    = 16'h0001;
    mem[2]    = 16'h0001;
    mem[3]    = br;
    mem[8'h4] = 16'hFFFF;
    do_reset();
    ifc.cmp_flag = cmp;
    push(0, 8'h00, 16'h0001);
    push(0, 8'h01, 16'h0001);
    push(0, 8'h02, 16'h0001);
`ifdef FETCH_BRANCH_EN
    if (exp_taken) push(1, 8'h10, 16'd4);
    else push(1, 8'h04, 16'd4);
`else
    push(0, 8'h03, br);
    push(1, 8'h04, 16'd4);
`endif
    do_start();
    wait_halt(name, 200);
  endtask

  initial begin
    int n;
    #400000;
    $display("FAIL watchdog checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset        = 1'b1;
    start        = 1'b0;
    ifc.cmp_flag = 2'b00;
    foreach (mem[i]) mem[i] = 16'h0000;

    // Reset, then idle and done in IDLE are both inert.
    do_reset();
    ifc.done = 1'b1;
    @(negedge clk);
    ifc.done = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_mem_rd", {31'd0, ifc.mem_rd}, 32'd0);
    check("idle_pc", {24'd0, pc}, 32'd0);
    check("idle_cnt", {16'd0, instr_count}, 32'd0);

    // One instruction then halt.
    mem[0] = 16'h2041;
    mem[1] = 16'hFFFF;
    push(0, 8'h00, 16'h2041);
    push(1, 8'h01, 16'd1);
    do_start();
    wait_halt("basic", 100);
    check("basic_cnt", {16'd0, instr_count}, 32'd1);

    // HALT ignores start.
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("halt_hold",
            {29'd0, halted, ifc.mem_rd, ifc.run}, 32'b100);
    end
    start = 1'b0;
    check("halt_pc_hold", {24'd0, pc}, 32'd1);

    // Slow memory: mem_rd held, inst unchanged, no run.
    mem[0]  = 16'h0A05;
    mem[1]  = 16'hFFFF;
    rdy_lat = 5;
    do_reset();
    push(0, 8'h00, 16'h0A05);
    push(1, 8'h01, 16'd1);
    do_start();
    n = 0;
    while (ifc.mem_rd && n < 50) begin
      n++;
      check("slow_inst", {16'd0, ifc.inst}, 32'd0);
      check("slow_run", {31'd0, ifc.run}, 32'd0);
      @(negedge clk);
    end
    check("slow_rd_cycles", n, 32'd5);
    wait_halt("slow", 100);
    rdy_lat = 1;

    // Branch format: cond 00 target 0x10, then cond 11.
    branch_case("br_eq_taken", 2'b00, 16'h0102, 1'b1);
    branch_case("br_eq_not", 2'b01, 16'h0102, 1'b0);
    branch_case("br_always", 2'b10, 16'h010E, 1'b1);
    branch_case("br_lt_taken", 2'b10, 16'h010A, 1'b1);

    // Reset mid-WAIT drops the pending done.
    mem[0]    = 16'h0003;
    done_auto = 1'b0;
    do_reset();
    push(0, 8'h00, 16'h0003);
    do_start();
    n = 0;
    while (!ifc.run && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wr_run_seen", {31'd0, ifc.run}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    ifc.done = 1'b1;
    @(negedge clk);
    ifc.done = 1'b0;
    @(negedge clk);
    check("wr_pc", {24'd0, pc}, 32'd0);
    check("wr_cnt", {16'd0, instr_count}, 32'd0);
    check("wr_strobes", {29'd0, ifc.mem_rd, ifc.run, halted}, 32'd0);
    check("wr_sb_empty", sb.size(), 32'd0);
    done_auto = 1'b1;

    // pc wraps FF -> 00 and fetching continues at 0.
    foreach (mem[i]) mem[i] = 16'h0001;
    do_reset();
    for (int i = 0; i < 256; i++) push(0, i[7:0], 16'h0001);
    push(1, 8'h00, 16'd256);
    do_start();
    n = 0;
    while (pc != 8'h01 && n < 100) begin
      @(negedge clk);
      n++;
    end
    mem[0] = 16'hFFFF;
    wait_halt("wrap", 3000);
    check("wrap_pc", {24'd0, pc}, 32'd0);
    check("wrap_cnt", {16'd0, instr_count}, 32'd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
